// File: rtl/reorder_buffer_if.sv
// Reorder buffer port bundle: allocation from rename, completion from execute, retire/free toward rename.
// Latency: none, signals only; the ROB uses the slave modport, its environment uses master.
// Backpressure: alloc_ready gates allocation; completion and retire/free have no backpressure.
// Optional ports occupancy/overflow_err exist only when ROB_OCCUPANCY_EN is defined.
interface reorder_buffer_if #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 5,
  parameter int AREG_W = 3
);
  localparam int IDX_W = $clog2(DEPTH);

  logic              alloc_valid;
  logic              alloc_ready;
  logic              alloc_dest_valid;
  logic [AREG_W-1:0] alloc_arch_dest;
  logic [PREG_W-1:0] alloc_new_preg;
  logic [PREG_W-1:0] alloc_old_preg;
  logic [IDX_W-1:0]  alloc_tag;
  logic              complete_valid;
  logic [IDX_W-1:0]  complete_tag;
  logic              retire_valid;
  logic [AREG_W-1:0] retire_arch;
  logic [PREG_W-1:0] retire_preg;
  logic              free_valid;
  logic [PREG_W-1:0] free_preg;
`ifdef ROB_OCCUPANCY_EN
  logic [IDX_W:0]    occupancy;
  logic              overflow_err;
`endif

  // Rename/execute side of the ROB.
  modport master (
    output alloc_valid, alloc_dest_valid, alloc_arch_dest, alloc_new_preg, alloc_old_preg,
    output complete_valid, complete_tag,
    input  alloc_ready, alloc_tag,
    input  retire_valid, retire_arch, retire_preg, free_valid, free_preg
`ifdef ROB_OCCUPANCY_EN
    , input occupancy, overflow_err
`endif
  );

  // The ROB itself.
  modport slave (
    input  alloc_valid, alloc_dest_valid, alloc_arch_dest, alloc_new_preg, alloc_old_preg,
    input  complete_valid, complete_tag,
    output alloc_ready, alloc_tag,
    output retire_valid, retire_arch, retire_preg, free_valid, free_preg
`ifdef ROB_OCCUPANCY_EN
    , output occupancy, overflow_err
`endif
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement ROB: records rename results, tracks completion, retires head and frees old preg.
// Latency: completion at edge E makes retire_valid high the following cycle; head advances at E+1.
// Backpressure: alloc_ready = !full from registered count only; rename holds alloc_valid while low.
// Optional feature macro ROB_OCCUPANCY_EN adds occupancy and sticky overflow_err outputs.
module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 5,
  parameter int AREG_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  reorder_buffer_if.slave rob
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(DEPTH);

  // Per-entry state.
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [DEPTH-1:0]  dest_valid_q, dest_valid_d;
  logic [AREG_W-1:0] arch_q [DEPTH];
  logic [AREG_W-1:0] arch_d [DEPTH];
  logic [PREG_W-1:0] new_preg_q [DEPTH];
  logic [PREG_W-1:0] new_preg_d [DEPTH];
  logic [PREG_W-1:0] old_preg_q [DEPTH];
  logic [PREG_W-1:0] old_preg_d [DEPTH];

  // Pointers and occupancy; head==tail is ambiguous, count tells empty from full.
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [IDX_W:0]    count_q, count_d;

  logic              alloc_ok;
  logic              alloc_fire;
  logic              retire_fire;
  logic              free_fire;
  logic              complete_hit;

`ifdef ROB_OCCUPANCY_EN
  logic              overflow_q, overflow_d;
`endif

  // Handshake decode, all from registered state so alloc_ready never sees this cycle's retire.
  always_comb begin
    alloc_ok     = (count_q != CNT_FULL);
    alloc_fire   = rob.alloc_valid && alloc_ok;
    retire_fire  = valid_q[head_q] && done_q[head_q];
    free_fire    = retire_fire && dest_valid_q[head_q];
    complete_hit = rob.complete_valid && valid_q[rob.complete_tag];
  end

  // Output drive: head payload is masked to zero unless the head actually retires.
  always_comb begin
    rob.alloc_ready  = alloc_ok;
    rob.alloc_tag    = tail_q;
    rob.retire_valid = retire_fire;
    rob.free_valid   = free_fire;
    rob.retire_arch  = retire_fire ? arch_q[head_q]     : '0;
    rob.retire_preg  = retire_fire ? new_preg_q[head_q] : '0;
    rob.free_preg    = free_fire   ? old_preg_q[head_q] : '0;
`ifdef ROB_OCCUPANCY_EN
    rob.occupancy    = count_q;
    rob.overflow_err = overflow_q;
`endif
  end

  // Next state: completion, then retirement of the head, then allocation at the tail.
  always_comb begin
    valid_d      = valid_q;
    done_d       = done_q;
    dest_valid_d = dest_valid_q;
    arch_d       = arch_q;
    new_preg_d   = new_preg_q;
    old_preg_d   = old_preg_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;

    // Only live entries may be marked done; the slot being allocated is not live yet.
    if (complete_hit) begin
      done_d[rob.complete_tag] = 1'b1;
    end

    if (retire_fire) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + 1'b1;
    end

    // Tail never aliases a retiring head: that would need a full ROB, which refuses allocation.
    if (alloc_fire) begin
      valid_d[tail_q]      = 1'b1;
      done_d[tail_q]       = 1'b0;
      dest_valid_d[tail_q] = rob.alloc_dest_valid;
      arch_d[tail_q]       = rob.alloc_arch_dest;
      new_preg_d[tail_q]   = rob.alloc_new_preg;
      old_preg_d[tail_q]   = rob.alloc_old_preg;
      tail_d               = tail_q + 1'b1;
    end

    case ({alloc_fire, retire_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

`ifdef ROB_OCCUPANCY_EN
  // Sticky flag for a completion aimed at a slot that holds no instruction.
  always_comb begin
    overflow_d = overflow_q | (rob.complete_valid && !valid_q[rob.complete_tag]);
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end
`endif

  // State registers; reset discards every in-flight entry at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      done_q       <= '0;
      dest_valid_q <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        arch_q[i]     <= '0;
        new_preg_q[i] <= '0;
        old_preg_q[i] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      done_q       <= done_d;
      dest_valid_q <= dest_valid_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        arch_q[i]     <= arch_d[i];
        new_preg_q[i] <= new_preg_d[i];
        old_preg_q[i] <= old_preg_d[i];
      end
    end
  end
endmodule
